// File: rtl/line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_pkg
// Description : Shared constants and state encoding for the line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package line_buffer_pkg;

  localparam int ROW_LENGTH = 1280;
  localparam int NUM_ROWS   = 720;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FINISH = 2'd3
  } lb_state_e;

endpackage : line_buffer_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Streams every row of a frame out of a BRAM with a one-cycle
//               read latency and presents a sliding three-row window
//               (top/middle/bottom) with dead zero rows above row 0 and
//               below the last row.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int row_length = ROW_LENGTH,
  parameter int num_rows   = NUM_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [row_length-1:0] rd_data,
  output logic [row_length-1:0] top_row,
  output logic [row_length-1:0] middle_row,
  output logic [row_length-1:0] bottom_row,
  output logic [ADDR_W-1:0]     calc_row_in,
  output logic                  calc_flg,
  output logic                  valid_set,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(num_rows - 1);

  lb_state_e               state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  // rd_en delayed by the BRAM latency: rd_data carries a row this cycle
  logic                    rd_vld_q, rd_vld_d;
  logic [row_length-1:0]   top_q, top_d;
  logic [row_length-1:0]   mid_q, mid_d;
  logic [row_length-1:0]   bot_q, bot_d;
  // set until the first shift; that shift only fills bottom and is not valid
  logic                    first_q, first_d;
  logic [ADDR_W-1:0]       calc_q, calc_d;
  logic                    flg_q, flg_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  logic                    shift_en;
  logic [row_length-1:0]   shift_val;

  // Next-state logic: FSM sequencing, address counter and window shifting
  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = rd_en_q;
    top_d     = top_q;
    mid_d     = mid_q;
    bot_d     = bot_q;
    first_d   = first_q;
    calc_d    = calc_q;
    flg_d     = flg_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    shift_en  = 1'b0;
    shift_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          flg_d     = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          top_d     = '0;
          mid_d     = '0;
          bot_d     = '0;
          first_d   = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_addr_q == LAST_ROW) begin
          rd_en_d = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        // the last row's data is still in flight on the first FLUSH cycle;
        // once it has landed, push the zero boundary row in
        if (!rd_vld_q) begin
          shift_en = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        flg_d   = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_vld_q) begin
      shift_en  = 1'b1;
      shift_val = rd_data;
    end

    if (shift_en) begin
      top_d   = mid_q;
      mid_d   = bot_q;
      bot_d   = shift_val;
      first_d = 1'b0;
      if (!first_q) begin
        valid_d = 1'b1;
        calc_d  = valid_q ? calc_q + 1'b1 : '0;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      first_q   <= 1'b0;
      calc_q    <= '0;
      flg_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      top_q     <= top_d;
      mid_q     <= mid_d;
      bot_q     <= bot_d;
      first_q   <= first_d;
      calc_q    <= calc_d;
      flg_q     <= flg_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign top_row     = top_q;
  assign middle_row  = mid_q;
  assign bottom_row  = bot_q;
  assign calc_row_in = calc_q;
  assign calc_flg    = flg_q;
  assign valid_set   = valid_q;
  assign done        = done_q;

endmodule : line_buffer
`default_nettype wire

// File: tb/tb_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buffer
// Description : Directed self-checking bench for line_buffer with 4-row and
//               2-row frames of 8-bit rows behind 1-cycle-latency BRAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start2;

  logic       rd_en4, rd_en2;
  logic [9:0] rd_addr4, rd_addr2;
  logic [7:0] rd_data4, rd_data2;
  logic [7:0] top4, mid4, bot4, top2, mid2, bot2;
  logic [9:0] calc4, calc2;
  logic       flg4, flg2, valid4, valid2, done4, done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem4 [4];
  logic [7:0] mem2 [2];
  logic [7:0] e_top4 [4];
  logic [7:0] e_mid4 [4];
  logic [7:0] e_bot4 [4];
  logic [7:0] e_top2 [2];
  logic [7:0] e_mid2 [2];
  logic [7:0] e_bot2 [2];

  line_buffer #(.row_length(8), .num_rows(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .top_row(top4), .middle_row(mid4), .bottom_row(bot4),
    .calc_row_in(calc4), .calc_flg(flg4), .valid_set(valid4), .done(done4)
  );

  line_buffer #(.row_length(8), .num_rows(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .top_row(top2), .middle_row(mid2), .bottom_row(bot2),
    .calc_row_in(calc2), .calc_flg(flg2), .valid_set(valid2), .done(done2)
  );

  always #5 clk = ~clk;

  // BRAM models: data appears one cycle after rd_en/rd_addr are sampled
  always @(posedge clk) begin
    if (rd_en4) rd_data4 <= mem4[rd_addr4[1:0]];
    if (rd_en2) rd_data2 <= mem2[rd_addr2[0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 4-row pass whose start is already driven for edge E0.
  // again_k: edge index at which a spurious start is driven (0 = none).
  // rst_k:   edge index at which rst_n is low for one edge (0 = none).
  task automatic pass4(input int again_k, input int rst_k);
    bit aborted = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      start4 = (again_k != 0) && (k + 1 == again_k);
      rst_n  = !((rst_k != 0) && (k + 1 == rst_k));
      if (rst_k != 0 && k >= rst_k) aborted = 1'b1;
      if (aborted) begin
        chk("abort_rd_en", rd_en4, 0);
        chk("abort_addr",  rd_addr4, 0);
        chk("abort_valid", valid4, 0);
        chk("abort_done",  done4, 0);
        chk("abort_busy",  flg4, 0);
        chk("abort_calc",  calc4, 0);
        chk("abort_win",   {top4, mid4, bot4}, 0);
      end else begin
        chk("rd_en4", rd_en4, k <= 3);
        if (k <= 3) chk("rd_addr4", rd_addr4, k);
        chk("valid4", valid4, (k >= 3) && (k <= 6));
        if (k >= 3 && k <= 6) begin
          chk("calc4", calc4, k - 3);
          chk("top4",  top4, e_top4[k-3]);
          chk("mid4",  mid4, e_mid4[k-3]);
          chk("bot4",  bot4, e_bot4[k-3]);
        end
        if (k >= 8) begin
          chk("calc4_hold", calc4, 3);
          chk("win4_hold", {top4, mid4, bot4}, {8'h18, 8'hFF, 8'h00});
        end
        chk("done4", done4, k == 7);
        chk("busy4", flg4, k <= 6);
      end
    end
  endtask

  // Runs one 2-row pass whose start is already driven for edge E0;
  // chain drives start in the cycle after done.
  task automatic pass2(input bit chain);
    for (int k = 0; k <= 5; k++) begin
      tick();
      start2 = chain && (k == 5);
      chk("rd_en2", rd_en2, k <= 1);
      if (k <= 1) chk("rd_addr2", rd_addr2, k);
      chk("valid2", valid2, (k >= 3) && (k <= 4));
      if (k >= 3 && k <= 4) begin
        chk("calc2", calc2, k - 3);
        chk("top2",  top2, e_top2[k-3]);
        chk("mid2",  mid2, e_mid2[k-3]);
        chk("bot2",  bot2, e_bot2[k-3]);
      end
      chk("done2", done2, k == 5);
      chk("busy2", flg2, k <= 4);
    end
  endtask

  initial begin
    mem4[0] = 8'h81; mem4[1] = 8'h3C; mem4[2] = 8'h18; mem4[3] = 8'hFF;
    mem2[0] = 8'h81; mem2[1] = 8'h3C;
    e_top4[0] = 8'h00; e_mid4[0] = 8'h81; e_bot4[0] = 8'h3C;
    e_top4[1] = 8'h81; e_mid4[1] = 8'h3C; e_bot4[1] = 8'h18;
    e_top4[2] = 8'h3C; e_mid4[2] = 8'h18; e_bot4[2] = 8'hFF;
    e_top4[3] = 8'h18; e_mid4[3] = 8'hFF; e_bot4[3] = 8'h00;
    e_top2[0] = 8'h00; e_mid2[0] = 8'h81; e_bot2[0] = 8'h3C;
    e_top2[1] = 8'h81; e_mid2[1] = 8'h3C; e_bot2[1] = 8'h00;

    rst_n  = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_rd_en", rd_en4, 0);
    chk("rst_addr",  rd_addr4, 0);
    chk("rst_valid", valid4, 0);
    chk("rst_busy",  flg4, 0);
    chk("rst_done",  done4, 0);
    chk("rst_calc",  calc4, 0);
    chk("rst_win",   {top4, mid4, bot4}, 0);

    // reset dominates start in the same cycle
    rst_n  = 1'b0;
    start4 = 1'b1;
    tick();
    rst_n  = 1'b1;
    start4 = 1'b0;
    chk("rst_dom_busy",  flg4, 0);
    chk("rst_dom_rd_en", rd_en4, 0);
    tick();
    chk("rst_dom_idle", flg4, 0);

    // plain pass
    start4 = 1'b1;
    pass4(0, 0);
    // spurious start while busy, and again during the FINISH cycle
    start4 = 1'b1;
    pass4(2, 0);
    start4 = 1'b1;
    pass4(7, 0);
    // reset on the second valid cycle, then a clean pass
    start4 = 1'b1;
    pass4(0, 5);
    start4 = 1'b1;
    pass4(0, 0);

    // two-row frames, back-to-back
    start2 = 1'b1;
    pass2(1'b1);
    pass2(1'b0);
    tick();
    chk("idle2_busy",  flg2, 0);
    chk("idle2_valid", valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_line_buffer
`default_nettype wire

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 Parameter row_length, default 1280, cells per row (width of every row bus).
REQ-002 Parameter num_rows, default 720, rows per frame (2..1024).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins one frame pass.
REQ-006 rd_en  output  1  BRAM read enable.
REQ-007 rd_addr  output  10  BRAM read row address.
REQ-008 rd_data  input  row_length  BRAM read data, valid one cycle after rd_en/rd_addr are sampled.
REQ-009 top_row / middle_row / bottom_row  output  row_length each  3-row window for the next-state stage.
REQ-010 calc_row_in  output  10  index of the row the current window computes.
REQ-011 calc_flg  output  1  busy; high while a frame pass is in progress.
REQ-012 valid_set  output  1  window and calc_row_in are valid this cycle.
REQ-013 done  output  1  single-cycle end-of-pass pulse.

Function
REQ-014 States SHALL be IDLE, READ, FLUSH, FINISH; all outputs registered.
REQ-015 IDLE + start: next state READ, calc_flg=1, rd_en=1, rd_addr=0, window cleared to zero.
REQ-016 READ: rd_addr increments by 1 per cycle with rd_en=1 through num_rows-1; on the cycle after issuing num_rows-1, rd_en=0, state FLUSH.
REQ-017 Shift: on each edge where rd_data is valid (rd_en delayed 1 cycle), top<=middle, middle<=bottom, bottom<=rd_data.
REQ-018 FLUSH: one extra shift with zero into bottom_row (dead boundary below last row); then FINISH.
REQ-019 valid_set=1 after every shift except the first (row 0 only in bottom); exactly num_rows valid cycles, consecutive, no gaps.
REQ-020 calc_row_in = 0 on first valid cycle, +1 per valid cycle, num_rows-1 on last; holds value when valid_set=0.
REQ-021 Row 0 window: top=0, middle=row0, bottom=row1; row num_rows-1 window: top=row N-2, middle=row N-1, bottom=0.
REQ-022 Latency: start sampled at edge E0; first valid_set visible after E3; last after E(num_rows+2).
REQ-023 FINISH: done=1 for one cycle, calc_flg=0, valid_set=0, return to IDLE; window holds last contents.
REQ-024 start while calc_flg=1 SHALL be ignored; start in the FINISH cycle ignored.
REQ-025 No flow control: downstream consumes every valid window in its cycle.

Reset
REQ-026 rst_n=0 at an edge: state IDLE; rd_en, valid_set, calc_flg, done = 0; rd_addr, calc_row_in = 0; all window rows = 0.
REQ-027 Reset mid-pass SHALL abort with no further valid_set or done; a pending BRAM read is discarded.
REQ-028 Reset dominates start in the same cycle.

Structure
REQ-029 Shared package: ROW_LENGTH, NUM_ROWS, ADDR_W=10, state enum.
REQ-030 Single module; no sub-module (counter and FSM inline).

Verification (row_length=8, num_rows=4, BRAM model with 1-cycle latency, rows 0x81,0x3C,0x18,0xFF)
REQ-031 Pulse start -> rd_addr 0,1,2,3 on consecutive cycles; valid_set high exactly 4 cycles starting 3 cycles after start; calc_row_in 0,1,2,3.
REQ-032 Same run -> windows (top,mid,bot): (00,81,3C), (81,3C,18), (3C,18,FF), (18,FF,00); done pulse 1 cycle after last valid.
REQ-033 Second start while calc_flg=1 -> ignored; exactly 4 valid cycles, one done.
REQ-034 rst_n low on the 2nd valid cycle -> next cycle all outputs zero, no further valid_set/done; new start gives a full correct pass.
REQ-035 num_rows=2 -> windows (00,r0,r1), (r0,r1,00); back-to-back start in the cycle after done -> second full pass identical.
